// File: rtl/issue_scoreboard_if.sv
// Handshake bundle between the ID stage, write-back and the issue scoreboard.
// The master modport is the pipeline side; the slave modport is the scoreboard.
interface issue_scoreboard_if #(
    parameter int STAT_W = 16
);
    logic              id_valid_i;
    logic              id_re1_i;
    logic [4:0]        id_ra1_i;
    logic              id_re2_i;
    logic [4:0]        id_ra2_i;
    logic              id_we_i;
    logic [4:0]        id_wa_i;
    logic              ex_busy_i;
    logic              wb_we_i;
    logic [4:0]        wb_wa_i;
    logic              flush_i;
    logic              drain_req_i;
    logic              issue_o;
    logic              stall_o;
    logic              drained_o;
    logic              err_o;
    logic [STAT_W-1:0] stall_cycles_o;

    modport master (
        output id_valid_i, id_re1_i, id_ra1_i, id_re2_i, id_ra2_i,
        output id_we_i, id_wa_i, ex_busy_i, wb_we_i, wb_wa_i,
        output flush_i, drain_req_i,
        input  issue_o, stall_o, drained_o, err_o, stall_cycles_o
    );

    modport slave (
        input  id_valid_i, id_re1_i, id_ra1_i, id_re2_i, id_ra2_i,
        input  id_we_i, id_wa_i, ex_busy_i, wb_we_i, wb_wa_i,
        input  flush_i, drain_req_i,
        output issue_o, stall_o, drained_o, err_o, stall_cycles_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gate issue on RAW/WAW
// hazards and a busy EX unit, with drain handshake, flush and stall statistics.
module issue_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    issue_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r     [NREG];
    logic [CNT_W-1:0]  cnt_nxt_s [NREG];
    logic              drained_r;
    logic              err_r;
    logic [STAT_W-1:0] stall_cnt_r;

    logic [CNT_W-1:0]  ra1_cnt_s;
    logic [CNT_W-1:0]  ra2_cnt_s;
    logic [CNT_W-1:0]  wa_cnt_s;
    logic [CNT_W-1:0]  wb_cnt_s;
    logic              rdy1_s;
    logic              rdy2_s;
    logic              raw_s;
    logic              waw_full_s;
    logic              block_s;
    logic              issue_s;
    logic              stall_s;
    logic              inc_s;
    logic              dec_s;
    logic              inc_hit_s;
    logic              dec_hit_s;
    logic              underflow_s;
    logic              all_zero_s;

    function automatic logic in_range(input logic [4:0] a);
        return (32'(a) < 32'(NREG));
    endfunction

    // A register is readable when nothing is pending, or the last pending
    // write is retiring this very cycle and the register file writes through.
    function automatic logic reg_ready(input logic [4:0] a, input logic [CNT_W-1:0] c,
                                       input logic wb_hit);
        return (a == 5'd0) || (c == CNT_ZERO) ||
               (WB_BYPASS && wb_hit && (c == CNT_ONE));
    endfunction

    // Counter lookups for the addressed registers; untracked addresses read as zero
    always_comb begin
        ra1_cnt_s = CNT_ZERO;
        ra2_cnt_s = CNT_ZERO;
        wa_cnt_s  = CNT_ZERO;
        wb_cnt_s  = CNT_ZERO;
        if (in_range(bus.id_ra1_i)) ra1_cnt_s = cnt_r[bus.id_ra1_i];
        else                        ra1_cnt_s = CNT_ZERO;
        if (in_range(bus.id_ra2_i)) ra2_cnt_s = cnt_r[bus.id_ra2_i];
        else                        ra2_cnt_s = CNT_ZERO;
        if (in_range(bus.id_wa_i))  wa_cnt_s  = cnt_r[bus.id_wa_i];
        else                        wa_cnt_s  = CNT_ZERO;
        if (in_range(bus.wb_wa_i))  wb_cnt_s  = cnt_r[bus.wb_wa_i];
        else                        wb_cnt_s  = CNT_ZERO;
    end

    // Hazard detection and issue/stall decision
    always_comb begin
        rdy1_s     = reg_ready(bus.id_ra1_i, ra1_cnt_s,
                               bus.wb_we_i && (bus.wb_wa_i == bus.id_ra1_i));
        rdy2_s     = reg_ready(bus.id_ra2_i, ra2_cnt_s,
                               bus.wb_we_i && (bus.wb_wa_i == bus.id_ra2_i));
        raw_s      = (bus.id_re1_i && !rdy1_s) || (bus.id_re2_i && !rdy2_s);
        // A same-cycle write-back deliberately does not relieve a full counter.
        waw_full_s = bus.id_we_i && (bus.id_wa_i != 5'd0) && (wa_cnt_s == CNT_MAX);
        block_s    = raw_s || waw_full_s || bus.ex_busy_i ||
                     (state_r != ST_RUN) || bus.flush_i;
        issue_s    = bus.id_valid_i && !block_s;
        stall_s    = bus.id_valid_i && block_s && !bus.flush_i;
        inc_s      = issue_s && bus.id_we_i && (bus.id_wa_i != 5'd0) && in_range(bus.id_wa_i);
        dec_s      = bus.wb_we_i && (bus.wb_wa_i != 5'd0) && in_range(bus.wb_wa_i);
    end

    // Next counter values: flush clears all, a matching inc/dec pair cancels
    always_comb begin
        inc_hit_s   = 1'b0;
        dec_hit_s   = 1'b0;
        underflow_s = 1'b0;
        all_zero_s  = 1'b1;
        for (int r = 0; r < NREG; r++) begin
            inc_hit_s  = inc_s && (32'(bus.id_wa_i) == 32'(r));
            dec_hit_s  = dec_s && (32'(bus.wb_wa_i) == 32'(r));
            all_zero_s = all_zero_s && (cnt_r[r] == CNT_ZERO);
            if (bus.flush_i || (r == 0)) begin
                cnt_nxt_s[r] = CNT_ZERO;
            end else if (inc_hit_s && !dec_hit_s) begin
                cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
            end else if (dec_hit_s && !inc_hit_s && (cnt_r[r] != CNT_ZERO)) begin
                cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
            end else begin
                cnt_nxt_s[r] = cnt_r[r];
            end
        end
        underflow_s = dec_s && !bus.flush_i && (wb_cnt_s == CNT_ZERO) &&
                      !(inc_s && (bus.id_wa_i == bus.wb_wa_i));
    end

    // Drain state machine next-state; DRAIN checks the counters as they stand now
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.drain_req_i) state_nxt_s = ST_DRAIN;
                else                 state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!bus.drain_req_i)                     state_nxt_s = ST_RUN;
                else if (all_zero_s && !bus.ex_busy_i)    state_nxt_s = ST_DRAINED;
                else                                      state_nxt_s = ST_DRAIN;
            end
            ST_DRAINED: begin
                if (!bus.drain_req_i) state_nxt_s = ST_RUN;
                else                  state_nxt_s = ST_DRAINED;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            drained_r   <= 1'b0;
            err_r       <= 1'b0;
            stall_cnt_r <= {STAT_W{1'b0}};
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else begin
            state_r   <= state_nxt_s;
            drained_r <= (state_nxt_s == ST_DRAINED);
            err_r     <= err_r || underflow_s;
            if (stall_s && (stall_cnt_r != STAT_MAX)) stall_cnt_r <= stall_cnt_r + STAT_ONE;
            else                                      stall_cnt_r <= stall_cnt_r;
            for (int r = 0; r < NREG; r++) begin
                cnt_r[r] <= cnt_nxt_s[r];
            end
        end
    end

    assign bus.issue_o        = issue_s;
    assign bus.stall_o        = stall_s;
    assign bus.drained_o      = drained_r;
    assign bus.err_o          = err_r;
    assign bus.stall_cycles_o = stall_cnt_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus random traffic, all
// checked every cycle against a counting reference model of the scoreboard.
module tb_issue_scoreboard;

    localparam int NREG   = 32;
    localparam int STAT_W = 16;
    localparam bit BYPASS = 1'b1;
    localparam int CMAX   = 3;
    localparam int SMAX   = 65535;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

    logic clk = 1'b0;
    logic rst;
    issue_scoreboard_if #(.STAT_W(STAT_W)) bus ();

    issue_scoreboard #(.NREG(NREG), .CNT_W(2), .STAT_W(STAT_W), .WB_BYPASS(BYPASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_cnt [NREG];
    int m_state;
    bit m_err;
    int m_stall;
    bit last_issue, last_stall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_state = M_RUN;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    function automatic bit m_ready(input int a);
        return (a == 0) || (m_cnt[a] == 0) ||
               (BYPASS && bus.wb_we_i && int'(bus.wb_wa_i) == a && m_cnt[a] == 1);
    endfunction

    task automatic clear_inputs();
        bus.id_valid_i = 1'b0; bus.id_re1_i = 1'b0; bus.id_ra1_i = 5'd0;
        bus.id_re2_i = 1'b0;   bus.id_ra2_i = 5'd0; bus.id_we_i = 1'b0;
        bus.id_wa_i = 5'd0;    bus.ex_busy_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_wa_i = 5'd0;    bus.flush_i = 1'b0;  bus.drain_req_i = 1'b0;
    endtask

    // One clock: compare against the model, then advance the model at the edge.
    task automatic tick();
        bit raw, waw, blk, e_issue, e_stall, all_zero;
        int wa, wb;
        #1;
        wa  = int'(bus.id_wa_i);
        wb  = int'(bus.wb_wa_i);
        raw = (bus.id_re1_i && !m_ready(int'(bus.id_ra1_i))) ||
              (bus.id_re2_i && !m_ready(int'(bus.id_ra2_i)));
        waw = bus.id_we_i && wa != 0 && m_cnt[wa] == CMAX;
        blk = raw || waw || bus.ex_busy_i || m_state != M_RUN || bus.flush_i;
        e_issue = bus.id_valid_i && !blk;
        e_stall = bus.id_valid_i && blk && !bus.flush_i;
        check_val("issue", 32'(bus.issue_o), 32'(e_issue));
        check_val("stall", 32'(bus.stall_o), 32'(e_stall));
        check_val("drained", 32'(bus.drained_o), 32'(m_state == M_DRAINED));
        check_val("err", 32'(bus.err_o), 32'(m_err));
        check_val("stall_cycles", 32'(bus.stall_cycles_o), 32'(m_stall));
        last_issue = bus.issue_o;
        last_stall = bus.stall_o;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            all_zero = 1'b1;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) all_zero = 1'b0;
            if (e_stall && m_stall < SMAX) m_stall++;
            if (bus.flush_i) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                if (e_issue && bus.id_we_i && wa != 0) m_cnt[wa]++;
                if (bus.wb_we_i && wb != 0) begin
                    if (m_cnt[wb] == 0) m_err = 1'b1;
                    else m_cnt[wb]--;
                end
            end
            case (m_state)
                M_RUN:   if (bus.drain_req_i) m_state = M_DRAIN;
                M_DRAIN: if (!bus.drain_req_i) m_state = M_RUN;
                         else if (all_zero && !bus.ex_busy_i) m_state = M_DRAINED;
                default: if (!bus.drain_req_i) m_state = M_RUN;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    endtask

    task automatic write_reg(input int r);
        clear_inputs(); bus.id_valid_i = 1'b1; bus.id_we_i = 1'b1; bus.id_wa_i = 5'(r); tick();
    endtask

    task automatic retire(input int r);
        clear_inputs(); bus.wb_we_i = 1'b1; bus.wb_wa_i = 5'(r); tick();
    endtask

    task automatic read_reg(input int r);
        clear_inputs(); bus.id_valid_i = 1'b1; bus.id_re1_i = 1'b1; bus.id_ra1_i = 5'(r);
    endtask

    initial begin
        int k, pick;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        tick();

        // RAW on r3, released by a same-cycle write-back
        write_reg(3);
        read_reg(3); tick();
        check_val("raw_stall", 32'(last_stall), 32'd1);
        tick();
        bus.wb_we_i = 1'b1; bus.wb_wa_i = 5'd3; tick();
        check_val("raw_bypass_issue", 32'(last_issue), 32'd1);

        // WAW limit on r5: full counter is not relieved by a same-cycle wb
        repeat (3) write_reg(5);
        clear_inputs(); bus.id_valid_i = 1'b1; bus.id_we_i = 1'b1; bus.id_wa_i = 5'd5;
        bus.wb_we_i = 1'b1; bus.wb_wa_i = 5'd5; tick();
        check_val("waw_full_stall", 32'(last_stall), 32'd1);
        bus.wb_we_i = 1'b0; tick();
        check_val("waw_next_issue", 32'(last_issue), 32'd1);
        repeat (3) retire(5);

        // r0 is never a hazard and a wb to it is not an underflow
        clear_inputs(); bus.id_valid_i = 1'b1; bus.id_re1_i = 1'b1; bus.id_re2_i = 1'b1;
        bus.id_we_i = 1'b1; bus.wb_we_i = 1'b1; tick();
        check_val("r0_issue", 32'(last_issue), 32'd1);
        check_val("r0_no_err", 32'(bus.err_o), 32'd0);
        tick();

        // Underflow on r7 is sticky
        retire(7);
        check_val("underflow_err", 32'(bus.err_o), 32'd1);
        clear_inputs(); repeat (3) tick();
        check_val("err_sticky", 32'(bus.err_o), 32'd1);
        do_reset();

        // Drain with pending r2, r9
        write_reg(2); write_reg(9);
        clear_inputs(); bus.drain_req_i = 1'b1; bus.id_valid_i = 1'b1; tick();
        tick();
        check_val("drain_no_issue", 32'(last_issue), 32'd0);
        bus.id_valid_i = 1'b0;
        bus.wb_we_i = 1'b1; bus.wb_wa_i = 5'd2; tick();
        bus.wb_wa_i = 5'd9; tick();
        bus.wb_we_i = 1'b0; tick();
        check_val("drained_high", 32'(bus.drained_o), 32'd1);
        bus.drain_req_i = 1'b0; tick();
        check_val("drained_low", 32'(bus.drained_o), 32'd0);
        bus.id_valid_i = 1'b1; tick();
        check_val("resume_issue", 32'(last_issue), 32'd1);

        // Drain request with nothing pending: drained two cycles later
        clear_inputs(); bus.drain_req_i = 1'b1; tick(); tick();
        check_val("quick_drained", 32'(bus.drained_o), 32'd1);
        clear_inputs(); tick();

        // Long RAW stall saturates the statistics counter
        write_reg(4);
        read_reg(4);
        repeat (70000) tick();
        check_val("stall_saturate", 32'(bus.stall_cycles_o), 32'd65535);
        bus.flush_i = 1'b1; tick();
        check_val("flush_no_stall", 32'(last_stall), 32'd0);
        bus.flush_i = 1'b0; tick();
        check_val("flush_then_issue", 32'(last_issue), 32'd1);

        // Reset in the middle of a drain with a pending write
        write_reg(6);
        clear_inputs(); bus.drain_req_i = 1'b1; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0; clear_inputs();
        check_val("rst_drained", 32'(bus.drained_o), 32'd0);
        check_val("rst_stats", 32'(bus.stall_cycles_o), 32'd0);
        read_reg(6); tick();
        check_val("rst_discards_pending", 32'(last_issue), 32'd1);

        // Random traffic over a small register window to provoke hazards
        clear_inputs();
        for (int c = 0; c < 4000; c++) begin
            bus.id_valid_i = ($urandom_range(0, 3) != 0);
            bus.id_re1_i   = $urandom_range(0, 1) == 1;
            bus.id_ra1_i   = 5'($urandom_range(0, 7));
            bus.id_re2_i   = $urandom_range(0, 1) == 1;
            bus.id_ra2_i   = 5'($urandom_range(0, 7));
            bus.id_we_i    = $urandom_range(0, 1) == 1;
            bus.id_wa_i    = 5'($urandom_range(0, 7));
            bus.ex_busy_i  = ($urandom_range(0, 7) == 0);
            bus.flush_i    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) bus.drain_req_i = ~bus.drain_req_i;
            bus.wb_we_i = 1'b0;
            bus.wb_wa_i = 5'd0;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 7);
                pick = -1;
                for (int i = 0; i < 8; i++)
                    if (pick < 0 && m_cnt[(k + i) % 8] > 0) pick = (k + i) % 8;
                if (pick > 0) begin
                    bus.wb_we_i = 1'b1;
                    bus.wb_wa_i = 5'(pick);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                bus.wb_we_i = 1'b1;
                bus.wb_wa_i = 5'($urandom_range(0, 7));
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
